mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_pkg.sv | 13 +
 rtl/mem_array.sv | 29 ++
 rtl/mem_responder.sv | 118 +++++++++++
 tb/tb_mem_responder.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the wait-state memory responder.
package mem_pkg;

  localparam int WAIT_CNT_W          = 4;
  localparam int DEFAULT_DEPTH_WORDS = 1024;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mem_array.sv
// Word-wide backing store: byte-enabled synchronous write, registered synchronous read.
module mem_array import mem_pkg::*; #(
  parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS
) (
  input  logic                           clk,
  input  logic                           i_we,
  input  logic                           i_re,
  input  logic [$clog2(DEPTH_WORDS)-1:0] i_addr,
  input  logic [31:0]                    i_wdata,
  input  logic [3:0]                     i_be,
  output logic [31:0]                    o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;

  // Contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int i = 0; i < 4; i++) begin
        if (i_be[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
      end
    end
    if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// Memory responder with WAIT_CYCLES wait states per access.
// Optional `MEM_BOUNDS_CHECK_EN flags word indices beyond DEPTH_WORDS instead of wrapping.
module mem_responder import mem_pkg::*; #(
  parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_t                r_state, w_next;
  logic [WAIT_CNT_W-1:0] r_cnt, w_cnt_next;
  logic                  r_we;
  logic [31:0]           r_addr, r_wdata;
  logic [3:0]            r_be;

  logic        w_idle, w_acc_we, w_acc_err, w_misalign, w_oob;
  logic [31:0] w_acc_addr, w_acc_wdata;
  logic [3:0]  w_acc_be;
  logic        w_enter_resp, w_mem_we, w_mem_re;
  logic [31:0] w_mem_rdata;

  // With zero wait states the access completes on the accepting edge, so the
  // array must see the live request rather than the captured copy.
  assign w_idle      = (r_state == IDLE);
  assign w_acc_we    = w_idle ? req_we    : r_we;
  assign w_acc_addr  = w_idle ? req_addr  : r_addr;
  assign w_acc_wdata = w_idle ? req_wdata : r_wdata;
  assign w_acc_be    = w_idle ? req_be    : r_be;
  assign w_misalign  = |w_acc_addr[1:0];

`ifdef MEM_BOUNDS_CHECK_EN
  assign w_oob = ({2'b00, w_acc_addr[31:2]} >= 32'(DEPTH_WORDS));
`else
  logic w_unused_hi_addr;
  assign w_unused_hi_addr = ^w_acc_addr[31:AW+2];
  assign w_oob            = 1'b0;
`endif

  assign w_acc_err = w_misalign | w_oob;

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (req_valid) begin
          if (WAIT_CYCLES == 0) begin
            w_next = RESP;
          end else begin
            w_next     = WAIT;
            w_cnt_next = WAIT_CNT_W'(WAIT_CYCLES);
          end
        end
      end
      WAIT: begin
        w_cnt_next = r_cnt - WAIT_CNT_W'(1);
        if (r_cnt == WAIT_CNT_W'(1)) w_next = RESP;
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_idle && req_valid) begin
        r_we    <= req_we;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_be    <= req_be;
      end
    end
  end

  // The array has no reset, so block its strobes while reset is held.
  assign w_enter_resp = reset && (w_next == RESP) && (r_state != RESP);
  assign w_mem_we     = w_enter_resp &&  w_acc_we && !w_acc_err;
  assign w_mem_re     = w_enter_resp && !w_acc_we && !w_acc_err;

  mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_re    (w_mem_re),
    .i_addr  (w_acc_addr[AW+1:2]),
    .i_wdata (w_acc_wdata),
    .i_be    (w_acc_be),
    .o_rdata (w_mem_rdata)
  );

  assign req_ready = w_idle;
  assign rsp_valid = (r_state == RESP);
  assign rsp_err   = rsp_valid && w_acc_err;
  assign rsp_rdata = (rsp_valid && !r_we && !w_acc_err) ? w_mem_rdata : 32'h0;

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench: one responder with one wait state, one with none.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset;

  logic        req_valid, req_ready, req_we, rsp_valid, rsp_err;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [3:0]  req_be;

  logic        req_valid_0, req_ready_0, req_we_0, rsp_valid_0, rsp_err_0;
  logic [31:0] req_addr_0, req_wdata_0, rsp_rdata_0;
  logic [3:0]  req_be_0;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut0 (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid_0),
    .req_ready (req_ready_0),
    .req_we    (req_we_0),
    .req_addr  (req_addr_0),
    .req_wdata (req_wdata_0),
    .req_be    (req_be_0),
    .rsp_valid (rsp_valid_0),
    .rsp_rdata (rsp_rdata_0),
    .rsp_err   (rsp_err_0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One access on the one-wait-state instance; inputs are scrambled right after
  // acceptance so the in-flight access must rely on its captured copy.
  task automatic access(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input logic [31:0] exp_rdata, input logic exp_err);
    @(negedge clk);
    chk({tag, " ready_idle"}, {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = ~we; req_addr = 32'hFFFF_FFFC; req_wdata = ~wdata; req_be = 4'hF;
    @(negedge clk);
    chk({tag, " wait_rsp_valid"}, {31'b0, rsp_valid}, 32'd0);
    chk({tag, " wait_ready"},     {31'b0, req_ready}, 32'd0);
    @(negedge clk);
    chk({tag, " rsp_valid"}, {31'b0, rsp_valid}, 32'd1);
    chk({tag, " rsp_ready"}, {31'b0, req_ready}, 32'd0);
    chk({tag, " rsp_rdata"}, rsp_rdata, exp_rdata);
    chk({tag, " rsp_err"},   {31'b0, rsp_err}, {31'b0, exp_err});
    @(negedge clk);
    chk({tag, " rsp_single"}, {31'b0, rsp_valid}, 32'd0);
    chk({tag, " ready_back"}, {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    reset = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    req_valid_0 = 1'b0; req_we_0 = 1'b0; req_addr_0 = '0; req_wdata_0 = '0; req_be_0 = '0;

    repeat (2) @(negedge clk);
    chk("rst rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst rsp_err",   {31'b0, rsp_err},   32'd0);
    chk("rst rsp_rdata", rsp_rdata,          32'd0);
    reset = 1'b1;
    #1;
    chk("rst ready_after", {31'b0, req_ready}, 32'd1);

    access("st_full",   1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0,         1'b0);
    access("ld_full",   1'b0, 32'h10, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0);
    access("st_lane0",  1'b1, 32'h10, 32'h0000_00AA, 4'b0001, 32'h0,      1'b0);
    access("ld_lane0",  1'b0, 32'h10, 32'h0,         4'h0, 32'hDEAD_BEAA, 1'b0);
    access("st_mis",    1'b1, 32'h11, 32'h1122_3344, 4'hF, 32'h0,         1'b1);
    access("ld_mis",    1'b0, 32'h13, 32'h0,         4'h0, 32'h0,         1'b1);
    access("ld_after_mis", 1'b0, 32'h10, 32'h0,      4'h0, 32'hDEAD_BEAA, 1'b0);

    access("st_w0",     1'b1, 32'h0,  32'h0BAD_F00D, 4'hF, 32'h0,         1'b0);
`ifdef MEM_BOUNDS_CHECK_EN
    access("ld_oob",    1'b0, 32'h1000, 32'h0,       4'h0, 32'h0,         1'b1);
`else
    access("ld_wrap",   1'b0, 32'h1000, 32'h0,       4'h0, 32'h0BAD_F00D, 1'b0);
`endif

    // Reset in the wait state of a store must abort it without writing.
    access("st_prior",  1'b1, 32'h20, 32'hCAFE_F00D, 4'hF, 32'h0,         1'b0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h1234_5678; req_be = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("abort rsp_valid_now", {31'b0, rsp_valid}, 32'd0);
    chk("abort ready_now",     {31'b0, req_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort rsp_valid_hold", {31'b0, rsp_valid}, 32'd0);
    end
    reset = 1'b1;
    #1;
    chk("abort ready_after", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    chk("abort rsp_valid_after", {31'b0, rsp_valid}, 32'd0);
    access("ld_prior",  1'b0, 32'h20, 32'h0,         4'h0, 32'hCAFE_F00D, 1'b0);

    // Zero wait states: store, then back-to-back loads with req_valid held.
    @(negedge clk);
    req_valid_0 = 1'b1; req_we_0 = 1'b1; req_addr_0 = 32'h0; req_wdata_0 = 32'h55AA_33CC; req_be_0 = 4'hF;
    @(posedge clk); #1;
    req_valid_0 = 1'b0; req_wdata_0 = 32'h0;
    @(negedge clk);
    chk("w0 st rsp_valid", {31'b0, rsp_valid_0}, 32'd1);
    chk("w0 st rsp_rdata", rsp_rdata_0, 32'h0);
    @(negedge clk);
    chk("w0 st single", {31'b0, rsp_valid_0}, 32'd0);
    req_valid_0 = 1'b1; req_we_0 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      chk("w0 b2b ready",     {31'b0, req_ready_0}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("w0 b2b rsp_valid", {31'b0, rsp_valid_0}, (i % 2 == 1) ? 32'd1 : 32'd0);
      if (i % 2 == 1) begin
        chk("w0 b2b rdata", rsp_rdata_0, 32'h55AA_33CC);
        chk("w0 b2b err",   {31'b0, rsp_err_0}, 32'd0);
      end
    end
    req_valid_0 = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
